mdu_sequencer: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations and owns the HI/LO registers. It models fixed multi-cycle latency with a small state machine and counter. It exports `busy` and `start` to the hazard/stall unit, which holds any D-stage MDU instruction while an operation is in flight.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 57 +++++
 rtl/mdu_sequencer.sv | 107 ++++++++++
 tb/tb_mdu_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode encodings, FSM state encoding and default latencies for the MDU.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_t;

    // True for the four opcodes that launch a multi-cycle operation.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo} for the given opcode.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] dvsr_s;
    logic [31:0] dvsr_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Signed/unsigned products and sign-magnitude division; a zero divisor is
    // forced to 1 so the divider never sees /0 (the result is discarded anyway).
    always_comb begin
        // Low 64 bits of the product of sign-extended operands equal the signed product.
        prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        prod_u = {32'd0, rs_data} * {32'd0, rt_data};

        // 0x80000000 negates to itself, which read unsigned is the correct 2^31 magnitude.
        abs_a  = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
        abs_b  = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
        dvsr_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
        dvsr_u = (rt_data == 32'd0) ? 32'd1 : rt_data;

        q_mag  = abs_a / dvsr_s;
        r_mag  = abs_a % dvsr_s;
        q_s    = (rs_data[31] ^ rt_data[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = rs_data[31] ? (~r_mag + 32'd1) : r_mag;
        q_u    = rs_data / dvsr_u;
        r_u    = rs_data % dvsr_u;

        result = 64'd0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {r_s, q_s};
            OP_DIVU:  result = {r_u, q_u};
            default:  result = 64'd0;
        endcase

        div_zero = ((op == OP_DIV) || (op == OP_DIVU)) && (rt_data == 32'd0);
    end

endmodule

// File: rtl/mdu_sequencer.sv
// MDU sequencer: owns HI/LO, models fixed MULT/DIV latency with a small FSM
// and down-counter, and exports start/busy to the hazard unit.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_skip;   // divide by zero: run the busy period but leave HI/LO alone
    logic [63:0] arith_result;
    logic        div_zero;
    logic        is_mul;
    logic        idle;
    logic        commit;
    logic        wr_hi;
    logic        wr_lo;

    mdu_arith u_arith (
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .result   (arith_result),
        .div_zero (div_zero)
    );

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        idle       = (state == ST_IDLE);
        start      = en && is_long_op(op);
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        busy       = !idle;
        commit     = busy && (cnt == 4'd0);
        wr_hi      = idle && en && (op == OP_MTHI);
        wr_lo      = idle && en && (op == OP_MTLO);

        case (state)
            ST_IDLE:    if (start) state_next = is_mul ? ST_MUL_RUN : ST_DIV_RUN;
            ST_MUL_RUN,
            ST_DIV_RUN: if (cnt == 4'd0) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // MFHI/MFLO read the architectural registers directly; no bypass of in-flight results.
    always_comb begin
        rdata = 32'd0;
        if (op == OP_MFHI)      rdata = hi;
        else if (op == OP_MFLO) rdata = lo;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Latency counter, pending result capture and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else if (idle) begin
            if (start) begin
                cnt       <= is_mul ? MUL_LOAD : DIV_LOAD;
                pend_hi   <= arith_result[63:32];
                pend_lo   <= arith_result[31:0];
                pend_skip <= div_zero;
            end
            if (wr_hi) hi <= rs_data;
            if (wr_lo) lo <= rs_data;
        end else if (commit) begin
            if (!pend_skip) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: table of arithmetic vectors, hand
// sequences for reset/back-to-back/ignored-op cases, then random traffic,
// all tracked by a cycle-level behavioural model.
module tb_mdu_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_skip;
    int          m_rem;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Architectural result of a long op from plain integer arithmetic.
    task automatic ref_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output logic skip);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        rh = 0; rl = 0; skip = 0;
        case (o)
            MULT: begin sq = sa * sb; rh = sq[63:32]; rl = sq[31:0]; end
            MULTU: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            DIV: if (b == 0) skip = 1;
                 else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            DIVU: if (b == 0) skip = 1;
                  else begin rl = a / b; rh = a % b; end
            default: ;
        endcase
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
    task automatic step(input logic r, input logic e, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        logic        e_start;
        logic [31:0] e_rd;
        @(negedge clk);
        reset = r; en = e; op = o; rs_data = a; rt_data = b;
        cyc++;
        #1;
        e_start = e && (o >= MULT) && (o <= DIVU);
        e_rd    = (o == MFHI) ? m_hi : (o == MFLO) ? m_lo : 32'd0;
        chk("start", 32'(start), 32'(e_start));
        chk("busy",  32'(busy),  32'(m_rem > 0));
        chk("hi",    hi, m_hi);
        chk("lo",    lo, m_lo);
        chk("rdata", rdata, e_rd);
        if (r) begin
            m_hi = 0; m_lo = 0; m_rem = 0; m_skip = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && !m_skip) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (e_start) begin
            ref_result(o, a, b, m_phi, m_plo, m_skip);
            m_rem = (o == MULT || o == MULTU) ? MC : DC;
        end else if (e && o == MTHI) begin
            m_hi = a;
        end else if (e && o == MTLO) begin
            m_lo = a;
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{DIVU,  32'd7,        32'd0,        32'hAAAAAAAA, 32'h55555555};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[7] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{DIV,   32'd5,        32'd0,        32'hAAAAAAAA, 32'h55555555};
        vecs[9] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset = 1; en = 0; op = NONE; rs_data = 0; rt_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_skip = 0; m_rem = 0;

        // Table: preload HI/LO, launch, watch the busy window, check the committed result.
        foreach (vecs[i]) begin
            n = (vecs[i].op == MULT || vecs[i].op == MULTU) ? MC : DC;
            step(0, 1, MTHI, 32'hAAAAAAAA, 0);
            step(0, 1, MTLO, 32'h55555555, 0);
            step(0, 1, vecs[i].op, vecs[i].rs, vecs[i].rt);
            chk("tbl_start", 32'(start), 32'd1);
            chk("tbl_idle", 32'(busy), 32'd0);
            for (int k = 0; k < n; k++) begin
                step(0, 0, NONE, 0, 0);
                chk("tbl_busy", 32'(busy), 32'd1);
            end
            step(0, 1, MFHI, 0, 0);
            chk("tbl_done", 32'(busy), 32'd0);
            chk("tbl_hi", hi, vecs[i].hi);
            chk("tbl_lo", lo, vecs[i].lo);
            chk("tbl_rdata", rdata, vecs[i].hi);
        end

        // MTHI then MFHI in the next cycle.
        step(0, 1, MTHI, 32'h12345678, 0);
        step(0, 1, MFHI, 0, 0);
        chk("mfhi_rd", rdata, 32'h12345678);

        // MTLO while busy is ignored.
        step(0, 1, MTLO, 32'h0000BEEF, 0);
        step(0, 1, MULT, 32'd0, 32'd0);
        step(0, 1, MTLO, 32'hDEADDEAD, 0);
        chk("mtlo_busy", lo, 32'h0000BEEF);
        repeat (MC) step(0, 0, NONE, 0, 0);
        chk("mtlo_after", lo, 32'd0);

        // Reset four cycles into a DIV discards it.
        step(0, 1, MTHI, 32'h11111111, 0);
        step(0, 1, MTLO, 32'h22222222, 0);
        step(0, 1, DIV, 32'd100, 32'd7);
        repeat (3) step(0, 0, NONE, 0, 0);
        step(1, 0, NONE, 0, 0);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        step(0, 0, NONE, 0, 0);
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);
        repeat (DC + 2) step(0, 0, NONE, 0, 0);
        chk("rst_nocommit_hi", hi, 32'd0);
        chk("rst_nocommit_lo", lo, 32'd0);

        // Back-to-back MULTs: second start on the first non-busy cycle.
        step(0, 1, MULT, 32'd3, 32'd4);
        repeat (MC) step(0, 0, NONE, 0, 0);
        step(0, 1, MULT, 32'd5, 32'd6);
        chk("b2b_idle", 32'(busy), 32'd0);
        chk("b2b_start", 32'(start), 32'd1);
        chk("b2b_lo1", lo, 32'd12);
        for (int k = 0; k < MC; k++) begin
            step(0, 0, NONE, 0, 0);
            chk("b2b_busy2", 32'(busy), 32'd1);
        end
        step(0, 0, NONE, 0, 0);
        chk("b2b_lo2", lo, 32'd30);
        chk("b2b_hi2", hi, 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
